// File: rtl/func_gen_pkg.sv
// -----------------------------------------------------------------------------
// func_gen_pkg
// Shared types and constants for the function-generator coefficient loader.
//   wave_type_t    : waveform selection driven to the amplitude controller
//   loader_state_t : coefficient loader FSM states
//   NUM_COEF_WORDS : 32-bit coefficient words per frame (cos0, cos1, sin0, sin1)
//   COEF_BYTES     : payload bytes per frame
//   is_preset()    : true when a wave request names one of the built-in presets
// -----------------------------------------------------------------------------
package func_gen_pkg;

  localparam int NUM_COEF_WORDS = 4;
  localparam int COEF_BYTES     = 16;

  typedef enum logic [2:0] {
    SINE     = 3'd0,
    SQUARE   = 3'd1,
    SAW      = 3'd2,
    TRIANGLE = 3'd3,
    CUSTOM   = 3'd4
  } wave_type_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    PEND   = 3'd3,
    COMMIT = 3'd4
  } loader_state_t;

  function automatic logic is_preset(input logic [2:0] req);
    return (req <= 3'd3);
  endfunction

endpackage

// File: rtl/func_gen_byte_packer.sv
// -----------------------------------------------------------------------------
// func_gen_byte_packer
// Shadow storage for an incoming coefficient frame. Byte slot k (0-based,
// arrival order) lands in word k/4 at bit position [31-8*(k%4) -: 8], so the
// first byte of each word is its most significant byte.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the shadow)
//   clear      : synchronous clear of every shadow byte (new/restarted frame)
//   wr_en      : write wr_byte into slot wr_idx
//   wr_idx     : byte slot 0 .. 4*NUM_WORDS-1
//   wr_byte    : byte value
//   words      : NUM_WORDS x 32-bit shadow words
// -----------------------------------------------------------------------------
module func_gen_byte_packer #(
  parameter int NUM_WORDS = 4,
  parameter int IDX_W     = $clog2(4 * NUM_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_byte,
  output logic [31:0]      words [NUM_WORDS]
);

  localparam int FRAME_BYTES = 4 * NUM_WORDS;

  logic [7:0] bytes_reg [FRAME_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_BYTES; i++) bytes_reg[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < FRAME_BYTES; i++) bytes_reg[i] <= '0;
    end else if (wr_en) begin
      // Compare against each slot rather than indexing directly, so an
      // out-of-range index can never alias onto a real slot.
      for (int i = 0; i < FRAME_BYTES; i++) begin
        if (wr_idx == IDX_W'(i)) bytes_reg[i] <= wr_byte;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    assign words[gi] = {bytes_reg[4*gi], bytes_reg[4*gi+1],
                        bytes_reg[4*gi+2], bytes_reg[4*gi+3]};
  end

endmodule

// File: rtl/func_gen_coef_loader.sv
// -----------------------------------------------------------------------------
// func_gen_coef_loader
// Loads a frame of 4*NUM_WORDS coefficient bytes (MSB-first) into a shadow
// buffer and commits it to input_bus at the next waveform period boundary,
// switching wave_type to CUSTOM. While idle, preset wave-type requests are
// latched and applied at the next period boundary.
// Optional feature: define FUNC_GEN_COEF_CHECKSUM_EN to require one trailing
// byte equal to the XOR of all frame bytes before the frame may commit.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   frame_start         : pulse, begins (or restarts) a coefficient frame
//   byte_in/byte_valid  : coefficient byte stream
//   byte_ready          : loader accepts a byte this cycle
//   wave_req/_valid     : preset wave-type request (0..3 valid)
//   phase_wrap          : pulse at the waveform period boundary
//   wave_type           : wave type to the amplitude controller
//   input_bus           : committed coefficient words
//   busy                : FSM not idle
//   commit_done         : pulse, coincides with updated input_bus/wave_type
//   error               : pulse on abort, timeout, bad request or bad checksum
// -----------------------------------------------------------------------------
module func_gen_coef_loader
  import func_gen_pkg::*;
#(
  parameter int TIMEOUT   = 1023,
  parameter int NUM_WORDS = NUM_COEF_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic [2:0]  wave_req,
  input  logic        wave_req_valid,
  input  logic        phase_wrap,
  output logic [2:0]  wave_type,
  output logic [31:0] input_bus [NUM_WORDS],
  output logic        busy,
  output logic        commit_done,
  output logic        error
);

  localparam int FRAME_BYTES = 4 * NUM_WORDS;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam int TMO_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

  loader_state_t    state_reg, state_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             pending_reg, pending_next;
  wave_type_t       preset_reg, preset_next;
  wave_type_t       wave_type_reg, wave_type_next;
  logic             commit_done_reg, commit_done_next;
  logic             error_reg, error_next;
  logic             run_reg;
`ifdef FUNC_GEN_COEF_CHECKSUM_EN
  logic [7:0]       xor_reg, xor_next;
`endif

  logic             clear_frame;
  logic             shadow_wr;
  logic             commit_load;
  logic             restart;
  logic             new_preset;
  logic [31:0]      shadow [NUM_WORDS];

  // Reset release is retimed by one flop: the first edge after release only
  // arms the logic, so frame_start is first acted on at the second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_reg <= 1'b0;
    else        run_reg <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= '0;
      tmo_cnt_reg     <= '0;
      pending_reg     <= 1'b0;
      preset_reg      <= SINE;
      wave_type_reg   <= SINE;
      commit_done_reg <= 1'b0;
      error_reg       <= 1'b0;
`ifdef FUNC_GEN_COEF_CHECKSUM_EN
      xor_reg         <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      byte_cnt_reg    <= byte_cnt_next;
      tmo_cnt_reg     <= tmo_cnt_next;
      pending_reg     <= pending_next;
      preset_reg      <= preset_next;
      wave_type_reg   <= wave_type_next;
      commit_done_reg <= commit_done_next;
      error_reg       <= error_next;
`ifdef FUNC_GEN_COEF_CHECKSUM_EN
      xor_reg         <= xor_next;
`endif
    end
  end

  assign restart    = run_reg && frame_start &&
                      (state_reg == LOAD || state_reg == CHECK || state_reg == PEND);
  assign new_preset = wave_req_valid && is_preset(wave_req);

  always_comb begin
    state_next       = state_reg;
    byte_cnt_next    = byte_cnt_reg;
    tmo_cnt_next     = tmo_cnt_reg;
    pending_next     = pending_reg;
    preset_next      = preset_reg;
    wave_type_next   = wave_type_reg;
    commit_done_next = 1'b0;
    error_next       = 1'b0;
    clear_frame      = 1'b0;
    shadow_wr        = 1'b0;
    commit_load      = 1'b0;
`ifdef FUNC_GEN_COEF_CHECKSUM_EN
    xor_next         = xor_reg;
`endif

    if (restart) begin
      error_next  = 1'b1;
      clear_frame = 1'b1;
      state_next  = LOAD;
    end else if (run_reg) begin
      case (state_reg)
        IDLE: begin
          if (wave_req_valid) begin
            if (new_preset) begin
              pending_next = 1'b1;
              preset_next  = wave_type_t'(wave_req);
            end else begin
              error_next = 1'b1;
            end
          end
          // A request latched this cycle overwrites the pending one and must
          // wait for a strictly later wrap.
          if (pending_reg && phase_wrap && !new_preset) begin
            wave_type_next   = preset_reg;
            commit_done_next = 1'b1;
            pending_next     = 1'b0;
          end
          if (frame_start) begin
            clear_frame = 1'b1;
            state_next  = LOAD;
          end
        end

        LOAD: begin
          if (byte_valid) begin
            shadow_wr     = 1'b1;
            byte_cnt_next = byte_cnt_reg + 1'b1;
            tmo_cnt_next  = '0;
`ifdef FUNC_GEN_COEF_CHECKSUM_EN
            xor_next      = xor_reg ^ byte_in;
            if (byte_cnt_reg == LAST_BYTE) state_next = CHECK;
`else
            if (byte_cnt_reg == LAST_BYTE) state_next = PEND;
`endif
          end else if (tmo_cnt_reg == TMO_LAST) begin
            error_next = 1'b1;
            state_next = IDLE;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
          end
        end

`ifdef FUNC_GEN_COEF_CHECKSUM_EN
        CHECK: begin
          if (byte_valid) begin
            tmo_cnt_next = '0;
            if (byte_in == xor_reg) begin
              state_next = PEND;
            end else begin
              error_next = 1'b1;
              state_next = IDLE;
            end
          end else if (tmo_cnt_reg == TMO_LAST) begin
            error_next = 1'b1;
            state_next = IDLE;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 1'b1;
          end
        end
`endif

        PEND: begin
          if (phase_wrap) state_next = COMMIT;
        end

        COMMIT: begin
          commit_load      = 1'b1;
          wave_type_next   = CUSTOM;
          commit_done_next = 1'b1;
          pending_next     = 1'b0;
          state_next       = IDLE;
        end

        default: state_next = IDLE;
      endcase
    end

    if (clear_frame) begin
      byte_cnt_next = '0;
      tmo_cnt_next  = '0;
`ifdef FUNC_GEN_COEF_CHECKSUM_EN
      xor_next      = '0;
`endif
    end
  end

  func_gen_byte_packer #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (CNT_W)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear_frame),
    .wr_en   (shadow_wr),
    .wr_idx  (byte_cnt_reg),
    .wr_byte (byte_in),
    .words   (shadow)
  );

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_bus
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           input_bus[gi] <= '0;
      else if (commit_load) input_bus[gi] <= shadow[gi];
    end
  end

  assign wave_type   = wave_type_reg;
  assign busy        = (state_reg != IDLE);
  assign byte_ready  = (state_reg == LOAD) || (state_reg == CHECK);
  assign commit_done = commit_done_reg;
  assign error       = error_reg;

endmodule
